// File: rtl/seq_magnitude_compare.sv
// Multi-cycle magnitude comparator. Operands are captured over a valid/ready
// handshake and compared one SLICE-bit slice per clock, most significant slice
// first. The result comes back as a one-hot lt/eq/gt over a second handshake.
module seq_magnitude_compare #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned SLICE      = 16,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IdxW-1:0] TopIdx = IdxW'(NSLICE - 1);

  // Operands must split into whole slices.
  if (SLICE == 0 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("seq_magnitude_compare: WIDTH must be a non-zero multiple of SLICE");
  end

  typedef enum logic [1:0] {
    StIdle,
    StCmp,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             pend_q, pend_d;       // a differing slice has been seen
  logic             pend_lt_q, pend_lt_d; // verdict of that first differing slice
  logic             out_valid_q, out_valid_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic             slice_ne;
  logic             slice_lt;
  logic             fin_diff;
  logic             fin_lt;

  // Slice under examination; the top slice in signed mode gets its sign bit
  // flipped so that a plain unsigned compare orders two's-complement values.
  always_comb begin
    slice_a = a_q[idx_q*SLICE +: SLICE];
    slice_b = b_q[idx_q*SLICE +: SLICE];
    if (signed_q && (idx_q == TopIdx)) begin
      slice_a[SLICE-1] = ~slice_a[SLICE-1];
      slice_b[SLICE-1] = ~slice_b[SLICE-1];
    end
    slice_ne = (slice_a != slice_b);
    slice_lt = (slice_a < slice_b);
  end

  // Final verdict when the last slice is reached: an earlier difference wins.
  always_comb begin
    fin_diff = pend_q | slice_ne;
    fin_lt   = pend_q ? pend_lt_q : slice_lt;
  end

  // Next-state logic for the handshake FSM and the datapath registers.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    signed_d    = signed_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_lt_d   = pend_lt_q;
    out_valid_d = out_valid_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_d        = gt_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          signed_d  = signed_mode;
          idx_d     = TopIdx;
          pend_d    = 1'b0;
          pend_lt_d = 1'b0;
          state_d   = StCmp;
        end
      end

      StCmp: begin
        if ((EARLY_EXIT != 0) && slice_ne) begin
          lt_d        = slice_lt;
          gt_d        = ~slice_lt;
          eq_d        = 1'b0;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          // Only the first differing slice may set the pending verdict.
          if (slice_ne && !pend_q) begin
            pend_d    = 1'b1;
            pend_lt_d = slice_lt;
          end
          if (idx_q == '0) begin
            lt_d        = fin_diff & fin_lt;
            gt_d        = fin_diff & ~fin_lt;
            eq_d        = ~fin_diff;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end else begin
            idx_d = idx_q - IdxW'(1);
          end
        end
      end

      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          lt_d        = 1'b0;
          eq_d        = 1'b0;
          gt_d        = 1'b0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        lt_d        = 1'b0;
        eq_d        = 1'b0;
        gt_d        = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      idx_q       <= TopIdx;
      pend_q      <= 1'b0;
      pend_lt_q   <= 1'b0;
      out_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_lt_q   <= pend_lt_d;
      out_valid_q <= out_valid_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
    end
  end

  // Handshake and status outputs straight from the registers.
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = out_valid_q;
    lt        = lt_q;
    eq        = eq_q;
    gt        = gt_q;
  end

endmodule
